// File: rtl/axi4_r_sender_if.sv
// AXI4 R channel bundle used on both sides of the read-data return stage.
// The master modport drives a beat; the slave modport returns ready.
interface axi4_r_sender_if #(
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4
);
  logic [C_AXI_ID_WIDTH-1:0]   rid;
  logic [C_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic [C_AXI_USER_WIDTH-1:0] ruser;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport slave (
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_r_sender.sv
// Read-data return stage: forwards interconnect R bursts and synthesises SLVERR
// bursts for dropped AR transactions, arbitrating fairly at burst boundaries.
module axi4_r_sender #(
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int DROP_FIFO_DEPTH  = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_rst,
  input  logic                        l1_trans_drop,
  output logic                        l1_drop_ready,
  input  logic [C_AXI_ID_WIDTH-1:0]   s_axi4_arid,
  input  logic [7:0]                  s_axi4_arlen,
  input  logic [C_AXI_USER_WIDTH-1:0] s_axi4_aruser,
  axi4_r_sender_if.master             s_axi4_r,
  axi4_r_sender_if.slave              m_axi4_r
);

  localparam int PTR_W = $clog2(DROP_FIFO_DEPTH);
  localparam int CNT_W = $clog2(DROP_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DROP_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    ERR
  } state_t;

  state_t state, state_next;
  logic   last_err, last_err_next;

  logic [C_AXI_ID_WIDTH-1:0]   id_mem   [DROP_FIFO_DEPTH];
  logic [7:0]                  len_mem  [DROP_FIFO_DEPTH];
  logic [C_AXI_USER_WIDTH-1:0] user_mem [DROP_FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       beat_cnt;
  logic             full, push, pop, err_last;

  assign full          = (count == FULL_CNT);
  assign l1_drop_ready = ~full;
  assign push          = l1_trans_drop & ~full;
  assign err_last      = (beat_cnt == len_mem[rd_ptr]);
  assign pop           = (state == ERR) & s_axi4_r.rready & err_last;

  // Descriptor storage carries no reset; only pointers and count define validity.
  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      id_mem[wr_ptr]   <= s_axi4_arid;
      len_mem[wr_ptr]  <= s_axi4_arlen;
      user_mem[wr_ptr] <= s_axi4_aruser;
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_rst) begin
      beat_cnt <= '0;
    end else if ((state == ERR) && s_axi4_r.rready) begin
      beat_cnt <= err_last ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_rst) begin
      state    <= IDLE;
      last_err <= 1'b0;
    end else begin
      state    <= state_next;
      last_err <= last_err_next;
    end
  end

  // On a tie the error queue wins unless the previous grant already went to it.
  always_comb begin
    state_next        = state;
    last_err_next     = last_err;
    s_axi4_r.rid      = '0;
    s_axi4_r.rdata    = '0;
    s_axi4_r.rresp    = 2'b00;
    s_axi4_r.rlast    = 1'b0;
    s_axi4_r.ruser    = '0;
    s_axi4_r.rvalid   = 1'b0;
    m_axi4_r.rready   = 1'b0;

    case (state)
      IDLE: begin
        if ((count != '0) && (!m_axi4_r.rvalid || !last_err)) begin
          state_next    = ERR;
          last_err_next = 1'b1;
        end else if (m_axi4_r.rvalid) begin
          state_next    = FWD;
          last_err_next = 1'b0;
        end
      end
      FWD: begin
        s_axi4_r.rid    = m_axi4_r.rid;
        s_axi4_r.rdata  = m_axi4_r.rdata;
        s_axi4_r.rresp  = m_axi4_r.rresp;
        s_axi4_r.rlast  = m_axi4_r.rlast;
        s_axi4_r.ruser  = m_axi4_r.ruser;
        s_axi4_r.rvalid = m_axi4_r.rvalid;
        m_axi4_r.rready = s_axi4_r.rready;
        if (m_axi4_r.rvalid && s_axi4_r.rready && m_axi4_r.rlast) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        s_axi4_r.rid    = id_mem[rd_ptr];
        s_axi4_r.ruser  = user_mem[rd_ptr];
        s_axi4_r.rresp  = 2'b10;
        s_axi4_r.rlast  = err_last;
        s_axi4_r.rvalid = 1'b1;
        if (s_axi4_r.rready && err_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi4_r_sender.sv
// Scoreboard bench for axi4_r_sender: directed drops and master bursts push
// expected beats; a negedge monitor pops and compares every accepted beat.
module tb_axi4_r_sender;
  localparam int DW    = 64;
  localparam int IW    = 4;
  localparam int UW    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          axi4_aclk = 1'b0;
  logic          axi4_rst;
  logic          l1_trans_drop;
  logic          l1_drop_ready;
  logic [IW-1:0] s_axi4_arid;
  logic [7:0]    s_axi4_arlen;
  logic [UW-1:0] s_axi4_aruser;

  axi4_r_sender_if #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ID_WIDTH(IW), .C_AXI_USER_WIDTH(UW)) s_axi4_r ();
  axi4_r_sender_if #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ID_WIDTH(IW), .C_AXI_USER_WIDTH(UW)) m_axi4_r ();

  axi4_r_sender #(
    .C_AXI_DATA_WIDTH(DW),
    .C_AXI_ID_WIDTH  (IW),
    .C_AXI_USER_WIDTH(UW),
    .DROP_FIFO_DEPTH (DEPTH)
  ) dut (
    .axi4_aclk    (axi4_aclk),
    .axi4_rst     (axi4_rst),
    .l1_trans_drop(l1_trans_drop),
    .l1_drop_ready(l1_drop_ready),
    .s_axi4_arid  (s_axi4_arid),
    .s_axi4_arlen (s_axi4_arlen),
    .s_axi4_aruser(s_axi4_aruser),
    .s_axi4_r     (s_axi4_r),
    .m_axi4_r     (m_axi4_r)
  );

  always #5 axi4_aclk = ~axi4_aclk;

  beat_t exp_q[$];
  beat_t m_q[$];
  int    checks = 0;
  int    fails = 0;
  int    err_beats_seen = 0;
  logic  m_hs_seen = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t mon_beat;
  beat_t exp_beat;

  function automatic beat_t mk_beat(input logic [IW-1:0] id, input logic [DW-1:0] data,
                                    input logic [1:0] resp, input logic last, input logic [UW-1:0] user);
    beat_t b;
    b.id = id; b.data = data; b.resp = resp; b.last = last; b.user = user;
    return b;
  endfunction

  task automatic tick();
    @(posedge axi4_aclk);
    #2;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_err(input logic [IW-1:0] id, input logic [7:0] len, input logic [UW-1:0] user);
    for (int b = 0; b <= int'(len); b++) begin
      exp_q.push_back(mk_beat(id, '0, 2'b10, (b == int'(len)), user));
    end
  endtask

  task automatic apply_stimulus(input logic [IW-1:0] id, input logic [7:0] len, input logic [UW-1:0] user);
    l1_trans_drop = 1'b1;
    s_axi4_arid   = id;
    s_axi4_arlen  = len;
    s_axi4_aruser = user;
    tick();
    l1_trans_drop = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || m_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s: timeout with %0d expected beats and %0d master beats left, required 0",
               name, exp_q.size(), m_q.size());
      exp_q.delete();
      m_q.delete();
    end
    tick();
  endtask

  task automatic do_reset();
    axi4_rst      = 1'b1;
    l1_trans_drop = 1'b0;
    tick();
    tick();
    exp_q.delete();
    m_q.delete();
    axi4_rst = 1'b0;
    tick();
  endtask

  // Monitor: compares each accepted beat with the scoreboard and checks hold-while-stalled.
  always @(negedge axi4_aclk) begin
    m_hs_seen = m_axi4_r.rvalid && m_axi4_r.rready;
    if (axi4_rst) begin
      prev_stall = 1'b0;
    end else begin
      mon_beat = mk_beat(s_axi4_r.rid, s_axi4_r.rdata, s_axi4_r.rresp, s_axi4_r.rlast, s_axi4_r.ruser);
      if (prev_stall) begin
        checks++;
        if (!s_axi4_r.rvalid || mon_beat !== prev_beat) begin
          fails++;
          $display("[TB] FAIL hold_stable: got valid=%0b beat=0x%0h, expected valid=1 beat=0x%0h",
                   s_axi4_r.rvalid, mon_beat, prev_beat);
        end
      end
      if (s_axi4_r.rvalid && s_axi4_r.rready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_beat: got id=%0h resp=%0h last=%0b, expected no beat",
                   mon_beat.id, mon_beat.resp, mon_beat.last);
        end else begin
          exp_beat = exp_q.pop_front();
          if (mon_beat !== exp_beat) begin
            fails++;
            $display("[TB] FAIL beat_compare: got id=%0h data=%0h resp=%0h last=%0b user=%0h, expected id=%0h data=%0h resp=%0h last=%0b user=%0h",
                     mon_beat.id, mon_beat.data, mon_beat.resp, mon_beat.last, mon_beat.user,
                     exp_beat.id, exp_beat.data, exp_beat.resp, exp_beat.last, exp_beat.user);
          end
        end
        if (mon_beat.resp == 2'b10) err_beats_seen++;
      end
      prev_stall = s_axi4_r.rvalid && !s_axi4_r.rready;
      prev_beat  = mon_beat;
    end
  end

  // Interconnect model: presents queued master beats and retires them on handshake.
  initial begin
    m_axi4_r.rvalid = 1'b0;
    m_axi4_r.rid    = '0;
    m_axi4_r.rdata  = '0;
    m_axi4_r.rresp  = 2'b00;
    m_axi4_r.rlast  = 1'b0;
    m_axi4_r.ruser  = '0;
    forever begin
      @(posedge axi4_aclk);
      #1;
      if (m_hs_seen && m_q.size() != 0) void'(m_q.pop_front());
      if (m_q.size() != 0) begin
        m_axi4_r.rvalid = 1'b1;
        m_axi4_r.rid    = m_q[0].id;
        m_axi4_r.rdata  = m_q[0].data;
        m_axi4_r.rresp  = m_q[0].resp;
        m_axi4_r.rlast  = m_q[0].last;
        m_axi4_r.ruser  = m_q[0].user;
      end else begin
        m_axi4_r.rvalid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    axi4_rst        = 1'b1;
    l1_trans_drop   = 1'b0;
    s_axi4_arid     = '0;
    s_axi4_arlen    = '0;
    s_axi4_aruser   = '0;
    s_axi4_r.rready = 1'b0;
    tick();
    tick();
    check_output("rst_rvalid", 64'(s_axi4_r.rvalid), 64'd0);
    check_output("rst_m_rready", 64'(m_axi4_r.rready), 64'd0);
    check_output("rst_drop_ready", 64'(l1_drop_ready), 64'd1);
    check_output("rst_rlast", 64'(s_axi4_r.rlast), 64'd0);
    check_output("rst_rresp", 64'(s_axi4_r.rresp), 64'd0);
    axi4_rst = 1'b0;
    tick();

    $display("[TB] single drop id=3 len=3 user=5");
    s_axi4_r.rready = 1'b1;
    push_err(4'd3, 8'd3, 4'd5);
    apply_stimulus(4'd3, 8'd3, 4'd5);
    check_output("err_latency_t1", 64'(s_axi4_r.rvalid), 64'd0);
    tick();
    check_output("err_latency_t2", 64'(s_axi4_r.rvalid), 64'd1);
    check_output("err_first_rid", 64'(s_axi4_r.rid), 64'd3);
    wait_drain(20, "drain_single_drop");
    check_output("idle_rvalid", 64'(s_axi4_r.rvalid), 64'd0);
    check_output("idle_drop_ready", 64'(l1_drop_ready), 64'd1);

    $display("[TB] forwarded burst id=1 with toggling ready");
    m_q.push_back(mk_beat(4'd1, 64'hA, 2'b00, 1'b0, 4'd2));
    m_q.push_back(mk_beat(4'd1, 64'hB, 2'b00, 1'b1, 4'd2));
    exp_q.push_back(mk_beat(4'd1, 64'hA, 2'b00, 1'b0, 4'd2));
    exp_q.push_back(mk_beat(4'd1, 64'hB, 2'b00, 1'b1, 4'd2));
    tick();
    check_output("fwd_bubble_rvalid", 64'(s_axi4_r.rvalid), 64'd0);
    check_output("fwd_bubble_m_rready", 64'(m_axi4_r.rready), 64'd0);
    tick();
    check_output("fwd_rvalid", 64'(s_axi4_r.rvalid), 64'd1);
    check_output("fwd_rdata", s_axi4_r.rdata, 64'hA);
    check_output("fwd_m_rready_hi", 64'(m_axi4_r.rready), 64'd1);
    s_axi4_r.rready = 1'b0;
    #1;
    check_output("fwd_m_rready_lo", 64'(m_axi4_r.rready), 64'd0);
    for (int i = 0; i < 20 && m_q.size() != 0; i++) begin
      tick();
      s_axi4_r.rready = ~s_axi4_r.rready;
    end
    s_axi4_r.rready = 1'b1;
    wait_drain(10, "drain_fwd_burst");

    $display("[TB] fill drop FIFO during stalled forward burst");
    s_axi4_r.rready = 1'b0;
    m_q.push_back(mk_beat(4'd12, 64'h1111, 2'b00, 1'b0, 4'd7));
    m_q.push_back(mk_beat(4'd12, 64'h2222, 2'b00, 1'b1, 4'd7));
    exp_q.push_back(mk_beat(4'd12, 64'h1111, 2'b00, 1'b0, 4'd7));
    exp_q.push_back(mk_beat(4'd12, 64'h2222, 2'b00, 1'b1, 4'd7));
    push_err(4'd4, 8'd0, 4'd1);
    push_err(4'd5, 8'd1, 4'd2);
    push_err(4'd6, 8'd0, 4'd3);
    push_err(4'd7, 8'd2, 4'd4);
    push_err(4'd8, 8'd0, 4'd5);
    tick();
    tick();
    apply_stimulus(4'd4, 8'd0, 4'd1);
    apply_stimulus(4'd5, 8'd1, 4'd2);
    apply_stimulus(4'd6, 8'd0, 4'd3);
    check_output("drop_ready_at_3", 64'(l1_drop_ready), 64'd1);
    apply_stimulus(4'd7, 8'd2, 4'd4);
    check_output("drop_ready_full", 64'(l1_drop_ready), 64'd0);
    l1_trans_drop   = 1'b1;
    s_axi4_arid     = 4'd8;
    s_axi4_arlen    = 8'd0;
    s_axi4_aruser   = 4'd5;
    base            = err_beats_seen;
    s_axi4_r.rready = 1'b1;
    n = 0;
    while (!l1_drop_ready && n < 40) begin
      tick();
      n++;
    end
    check_output("drop_ready_reassert", 64'(l1_drop_ready), 64'd1);
    check_output("err_beats_at_reassert", 64'(err_beats_seen - base), 64'd1);
    tick();
    l1_trans_drop = 1'b0;
    wait_drain(80, "drain_full_fifo");

    $display("[TB] arbitration tie after reset");
    do_reset();
    s_axi4_r.rready = 1'b1;
    push_err(4'd9, 8'd1, 4'd6);
    exp_q.push_back(mk_beat(4'd2, 64'h33, 2'b00, 1'b1, 4'd1));
    push_err(4'd10, 8'd0, 4'd7);
    m_q.push_back(mk_beat(4'd2, 64'h33, 2'b00, 1'b1, 4'd1));
    apply_stimulus(4'd9, 8'd1, 4'd6);
    apply_stimulus(4'd10, 8'd0, 4'd7);
    wait_drain(30, "drain_tie");

    $display("[TB] max-length error burst");
    push_err(4'd11, 8'd255, 4'd8);
    apply_stimulus(4'd11, 8'd255, 4'd8);
    wait_drain(300, "drain_len255");
    push_err(4'd12, 8'd0, 4'd9);
    apply_stimulus(4'd12, 8'd0, 4'd9);
    wait_drain(10, "drain_after_len255");

    $display("[TB] reset during error burst");
    exp_q.push_back(mk_beat(4'd13, '0, 2'b10, 1'b0, 4'd10));
    exp_q.push_back(mk_beat(4'd13, '0, 2'b10, 1'b0, 4'd10));
    apply_stimulus(4'd13, 8'd7, 4'd10);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check_output("beats_before_reset", 64'(exp_q.size()), 64'd0);
    axi4_rst = 1'b1;
    tick();
    check_output("midrst_rvalid", 64'(s_axi4_r.rvalid), 64'd0);
    check_output("midrst_drop_ready", 64'(l1_drop_ready), 64'd1);
    check_output("midrst_m_rready", 64'(m_axi4_r.rready), 64'd0);
    axi4_rst = 1'b0;
    exp_q.delete();
    repeat (20) tick();
    check_output("post_rst_rvalid", 64'(s_axi4_r.rvalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
